// File: rtl/trace_pkg.sv
// Shared types for the writeback trace recorder: FIFO entry layout, beat
// phase and the header magic byte.
package trace_pkg;

    localparam logic [7:0] TRACE_MAGIC = 8'hA5;

    typedef struct packed {
        logic [15:0] stamp;
        logic [4:0]  wd;
        logic [31:0] wdata;
    } trace_entry_t;

    typedef enum logic {BEAT_HDR, BEAT_DATA} beat_t;

endpackage

// File: rtl/wb_trace_recorder_if.sv
// Valid/ready beat stream from the trace recorder to its sink.
interface wb_trace_recorder_if;

    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_data;

    modport master (output trace_valid, output trace_data, input trace_ready);
    modport slave  (input trace_valid, input trace_data, output trace_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; a pop on the same edge frees the slot
// for a push, so push+pop on a full FIFO is accepted.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  trace_entry_t           din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output trace_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is data only; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_trace_recorder.sv
// Captures architectural register writes with a cycle stamp and streams each
// as a header beat followed by a data beat.
module wb_trace_recorder
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [4:0]                wb_wd,
    input  logic [31:0]               wb_wdata,
    input  logic                      clear,
    wb_trace_recorder_if.master       trace,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [STAMP_W-1:0] stamp;
    beat_t              beat;
    trace_entry_t       entry;
    trace_entry_t       head;
    logic               full;
    logic               empty;
    logic               evt;
    logic               handshake;
    logic               pop;
    logic               drop;

    assign evt       = en && (wb_wd != 5'd0);
    assign handshake = trace.trace_valid && trace.trace_ready;
    assign pop       = handshake && (beat == BEAT_DATA);
    assign drop      = evt && full && !pop;
    assign entry     = '{stamp: 16'(stamp), wd: wb_wd, wdata: wb_wdata};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt),
        .pop   (pop),
        .din   (entry),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            stamp      <= '0;
            beat       <= BEAT_HDR;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            if (handshake) beat <= (beat == BEAT_HDR) ? BEAT_DATA : BEAT_HDR;
            // A drop on the same edge as clear wins and counts as the first drop.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= clear ? 16'd1 : sat_inc(drop_count);
            end else if (clear) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    assign trace.trace_valid = !empty;
    assign trace.trace_data  = empty ? 32'h0 :
                               (beat == BEAT_HDR) ? {TRACE_MAGIC, 3'b000, head.wd, head.stamp}
                                                  : head.wdata;

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Randomized and directed bench for wb_trace_recorder against a queue-based
// reference model of the recorded event stream.
module tb_wb_trace_recorder;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clear;
    logic [4:0]    wb_wd;
    logic [31:0]   wb_wdata;
    logic          overflow;
    logic [15:0]   drop_count;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    wb_trace_recorder_if tif ();

    wb_trace_recorder #(.DEPTH(DEPTH), .STAMP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wb_wd      (wb_wd),
        .wb_wdata   (wb_wdata),
        .clear      (clear),
        .trace      (tif),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [15:0] stamp;
        logic [4:0]  wd;
        logic [31:0] wdata;
    } ev_t;

    ev_t         q[$];
    bit          m_half;
    logic [15:0] m_stamp;
    logic [15:0] m_drops;
    bit          m_ovf;
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic bit m_valid();
        return q.size() != 0;
    endfunction

    function automatic logic [31:0] m_data();
        if (q.size() == 0) return 32'h0;
        return m_half ? q[0].wdata : {8'hA5, 3'b000, q[0].wd, q[0].stamp};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit r, input bit e, input logic [4:0] wd,
                        input logic [31:0] d, input bit rdy, input bit clr);
        bit full_b, adv, pop, evt, drop;
        rst = r; en = e; wb_wd = wd; wb_wdata = d; tif.trace_ready = rdy; clear = clr;
        @(posedge clk);
        if (!r) begin
            q.delete();
            m_half = 0; m_stamp = 16'h0; m_drops = 16'h0; m_ovf = 0;
        end else begin
            full_b = (q.size() == DEPTH);
            adv    = (q.size() != 0) && rdy;
            pop    = adv && m_half;
            evt    = e && (wd != 5'd0);
            drop   = evt && full_b && !pop;
            if (clr) begin m_ovf = 0; m_drops = 16'h0; end
            if (drop) begin
                m_ovf = 1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            end
            if (pop) void'(q.pop_front());
            if (adv) m_half = !m_half;
            if (evt && !drop) q.push_back('{m_stamp, wd, d});
            m_stamp = m_stamp + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, 5'd0, 32'h0, rdy, 0);
    endtask

    task automatic test_reset();
        step(0, 0, 5'd0, 32'h0, 0, 0);
        step(0, 1, 5'd3, 32'h1234, 1, 0);
        tests_run++;
        if (tif.trace_valid !== 1'b0 || tif.trace_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_stream: valid=%b data=%h, want 0/00000000", tif.trace_valid, tif.trace_data);
        end
        tests_run++;
        if (fifo_count !== '0 || overflow !== 1'b0 || drop_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_status: count=%0d ovf=%b drops=%0d, want 0/0/0", fifo_count, overflow, drop_count);
        end
    endtask

    task automatic test_single_write();
        step(0, 0, 5'd0, 32'h0, 1, 0);
        for (int i = 0; i < 5; i++) idle(1);
        step(1, 1, 5'd1, 32'h00000020, 1, 0);
        tests_run++;
        if (tif.trace_valid !== 1'b1 || tif.trace_data !== 32'hA5010005) begin
            tests_failed++;
            $display("FAIL single_hdr: valid=%b data=%h, want 1/a5010005", tif.trace_valid, tif.trace_data);
        end
        idle(1);
        tests_run++;
        if (tif.trace_valid !== 1'b1 || tif.trace_data !== 32'h00000020) begin
            tests_failed++;
            $display("FAIL single_data: valid=%b data=%h, want 1/00000020", tif.trace_valid, tif.trace_data);
        end
        idle(1);
        tests_run++;
        if (tif.trace_valid !== 1'b0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL single_drain: valid=%b count=%0d, want 0/0", tif.trace_valid, fifo_count);
        end
    endtask

    task automatic test_zero_filter();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 5'd0, 32'hDEADBEEF, 1, 0);
            tests_run++;
            if (tif.trace_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_filter_valid[%0d]: valid=%b, want 0", i, tif.trace_valid);
            end
        end
        tests_run++;
        if (drop_count !== 16'h0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL zero_filter_drops: drops=%0d count=%0d, want 0/0", drop_count, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d [3];
        logic [31:0] want;
        step(0, 0, 5'd0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            step(1, 1, 5'(2 + i), d[i], 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (fifo_count !== CW'(3) || tif.trace_valid !== 1'b1 || tif.trace_data !== 32'hA5020000) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: count=%0d valid=%b data=%h, want 3/1/a5020000",
                         i, fifo_count, tif.trace_valid, tif.trace_data);
            end
            idle(0);
        end
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? {8'hA5, 3'b000, 5'(2 + k / 2), 16'(k / 2)} : d[k / 2];
            tests_run++;
            if (tif.trace_valid !== 1'b1 || tif.trace_data !== want) begin
                tests_failed++;
                $display("FAIL bp_beat[%0d]: valid=%b data=%h, want 1/%h", k, tif.trace_valid, tif.trace_data, want);
            end
            idle(1);
        end
        tests_run++;
        if (tif.trace_valid !== 1'b0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL bp_drain: valid=%b count=%0d, want 0/0", tif.trace_valid, fifo_count);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 5'd0, 32'h0, 0, 0);
        for (int i = 0; i < 18; i++)
            step(1, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0);
        tests_run++;
        if (fifo_count !== CW'(16) || overflow !== 1'b1 || drop_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL ovf_state: count=%0d ovf=%b drops=%0d, want 16/1/2", fifo_count, overflow, drop_count);
        end
        tests_run++;
        if (tif.trace_data !== m_data()) begin
            tests_failed++;
            $display("FAIL ovf_head: data=%h, want %h", tif.trace_data, m_data());
        end
        step(1, 0, 5'd0, 32'h0, 0, 1);
        tests_run++;
        if (fifo_count !== CW'(16) || overflow !== 1'b0 || drop_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL ovf_clear: count=%0d ovf=%b drops=%0d, want 16/0/0", fifo_count, overflow, drop_count);
        end
    endtask

    task automatic test_full_push_pop();
        idle(1);
        tests_run++;
        if (fifo_count !== CW'(16) || tif.trace_data !== m_data()) begin
            tests_failed++;
            $display("FAIL fpp_data_beat: count=%0d data=%h, want 16/%h", fifo_count, tif.trace_data, m_data());
        end
        step(1, 1, 5'd9, $urandom, 1, 0);
        tests_run++;
        if (fifo_count !== CW'(16) || drop_count !== 16'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fpp_accept: count=%0d drops=%0d ovf=%b, want 16/0/0", fifo_count, drop_count, overflow);
        end
        tests_run++;
        if (tif.trace_data !== m_data() || q[DEPTH-1].wd !== 5'd9) begin
            tests_failed++;
            $display("FAIL fpp_head: data=%h, want %h", tif.trace_data, m_data());
        end
        step(1, 1, 5'd10, $urandom, 0, 1);
        tests_run++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL clear_vs_drop: ovf=%b drops=%0d, want 1/1", overflow, drop_count);
        end
    endtask

    task automatic test_reset_midrecord();
        idle(1);
        tests_run++;
        if (tif.trace_valid !== 1'b1 || tif.trace_data !== m_data() || !m_half) begin
            tests_failed++;
            $display("FAIL mid_data_beat: valid=%b data=%h, want 1/%h", tif.trace_valid, tif.trace_data, m_data());
        end
        step(0, 0, 5'd0, 32'h0, 0, 0);
        tests_run++;
        if (tif.trace_valid !== 1'b0 || fifo_count !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b count=%0d, want 0/0", tif.trace_valid, fifo_count);
        end
        step(1, 1, 5'd7, $urandom, 0, 0);
        tests_run++;
        if (tif.trace_data !== 32'hA5070000) begin
            tests_failed++;
            $display("FAIL mid_stamp_restart: data=%h, want a5070000", tif.trace_data);
        end
    endtask

    task automatic test_random();
        bit r, e, rdy, clr;
        logic [4:0] wd;
        step(0, 0, 5'd0, 32'h0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 200) != 0);
            e   = ($urandom_range(0, 3) != 0);
            wd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdy = (i % 200 < 80) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            step(r, e, wd, $urandom, rdy, clr);
            tests_run++;
            if ({tif.trace_valid, tif.trace_data, fifo_count, overflow, drop_count} !==
                {m_valid(), m_data(), CW'(q.size()), m_ovf, m_drops}) begin
                tests_failed++;
                $display("FAIL random[%0d]: valid=%b data=%h count=%0d ovf=%b drops=%0d, want %b/%h/%0d/%b/%0d",
                         i, tif.trace_valid, tif.trace_data, fifo_count, overflow, drop_count,
                         m_valid(), m_data(), q.size(), m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0; wb_wd = '0; wb_wdata = '0; tif.trace_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_zero_filter();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_midrecord();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_trace_recorder.md
Name: wb_trace_recorder

Overview:
- Synthesizable capture block for the CPU writeback stage.
- Records every architectural register write (dest reg, data, cycle stamp) into an internal FIFO and serializes it as a 2-beat valid/ready word stream for a host, UART bridge or bench sink.
- Its record format is the one the writeback-checking bench consumes ("$N=0x..."), so traces can be compared off-chip.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- STAMP_W, 16, cycle-stamp width; fixed at 16 for the header layout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- en  in  1  capture enable; events are ignored while 0
- wb_wd  in  5  writeback destination register; 0 means no write
- wb_wdata  in  32  writeback data
- clear  in  1  clears overflow and drop_count
- trace_valid  out  1  a beat is presented
- trace_ready  in  1  sink accepts the beat
- trace_data  out  32  beat payload
- overflow  out  1  sticky: at least one event was dropped
- drop_count  out  16  saturating count of dropped events
- fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst==0 at a rising edge):
  - fifo empty; fifo_count=0; beat=HDR.
  - overflow=0, drop_count=0, cycle stamp=0.
  - trace_valid=0; trace_data=0 whenever trace_valid=0.
- Cycle stamp:
  - 16-bit counter, +1 every clock while not in reset, wraps 0xFFFF->0x0000.
  - An event captured at an edge carries the stamp value before that edge's increment.
- Event definition: en==1 && wb_wd!=0 at a rising edge. Writes to $0 are never recorded and never counted as drops.
- Push:
  - Entry = {stamp, wb_wd, wb_wdata}.
  - Accepted if the FIFO is not full, or if it is full and a pop completes on the same edge (simultaneous push+pop on full is legal; count unchanged).
  - Otherwise the event is dropped: overflow<=1; drop_count<=drop_count+1, saturating at 0xFFFF.
- Serializer, beat register {HDR, DATA}:
  - trace_valid = fifo not empty.
  - HDR: trace_data = {8'hA5, 3'b000, wd[4:0], stamp[15:0]}.
  - DATA: trace_data = wdata of head entry.
  - HDR & valid & ready -> DATA.
  - DATA & valid & ready -> pop head, -> HDR.
  - No ready -> hold state and data stable (AXI-style: valid never drops before handshake).
- Latency: an event captured at edge N gives trace_valid=1 in the cycle after edge N when the FIFO was empty. Best-case throughput: 1 event per 2 cycles.
- Empty while push+pop on the same edge: impossible, since pop requires valid.
- clear:
  - Synchronous; zeros overflow and drop_count.
  - If a drop happens on the same edge, the drop wins: overflow=1, drop_count=1.
  - Does not flush the FIFO.
- Mid-stream reset: the FIFO flushes, and trace_valid falls in the cycle after the reset edge even without a handshake. A sink must discard a partial record.
- en deassertion: affects capture only; the FIFO continues to drain.

Decomposition:
- Package trace_pkg:
  - typedef trace_entry_t (stamp 16, wd 5, wdata 32)
  - enum beat_t {BEAT_HDR, BEAT_DATA}
  - localparam TRACE_MAGIC = 8'hA5
- Sub-module trace_fifo (generic sync FIFO of trace_entry_t, DEPTH):
  - Ports push/pop/full/empty/count/head.
  - Pop-frees-slot rule implemented inside it.
- wb_trace_recorder holds the stamp counter, the drop logic and the beat FSM.

Test Plan:
- Single write: reset, en=1, wb_wd=1, wb_wdata=0x00000020 at stamp 5, ready=1 -> beats 0xA5010005 then 0x00000020; fifo_count returns to 0.
- $0 filter: wb_wd=0, wb_wdata=0xDEADBEEF for 10 cycles -> trace_valid stays 0, drop_count=0.
- Backpressure: ready=0 while 3 events (regs 2,3,4) are captured -> fifo_count=3; trace_data holds the header for reg 2 stable. Raising ready gives 6 beats in reg order 2,3,4.
- Overflow: ready=0, 18 consecutive events with DEPTH=16 -> fifo_count=16, overflow=1, drop_count=2. A clear pulse then makes both 0 and the FIFO keeps 16 entries.
- Full push+pop: FIFO full, in DATA beat, ready=1, new event on the same edge -> accepted, fifo_count stays 16, drop_count unchanged.
- Reset mid-record: drive rst=0 while in the DATA beat -> next cycle trace_valid=0 and fifo_count=0. After release the stamp restarts at 0.
